// File: rtl/serial_readout_receiver_if.sv
// Bundles the chip-side serial readout lanes/strobes with the record valid/ready output.
// The slave modport is the receiver; the master modport is whatever drives it and consumes records.
interface serial_readout_receiver_if #(
  parameter int TIME_W = 16,
  parameter int CH_W   = 14
);
  logic [1:0]        serial_in;
  logic              sl_time;
  logic              sl_ch;
  logic              sending_data;
  logic              out_ready;
  logic [TIME_W-1:0] time_word;
  logic [CH_W-1:0]   ch_word;
  logic              out_valid;

  modport master (
    output serial_in, sl_time, sl_ch, sending_data, out_ready,
    input  time_word, ch_word, out_valid
  );

  modport slave (
    input  serial_in, sl_time, sl_ch, sending_data, out_ready,
    output time_word, ch_word, out_valid
  );
endinterface

// File: rtl/serial_readout_receiver.sv
// Deserializes 2-lane readout records (timestamp pairs then channel pairs) into
// a one-entry valid/ready output register with frame-error and overflow reporting.
module serial_readout_receiver #(
  parameter int TIME_W = 16,
  parameter int CH_W   = 14,
  parameter int CNT_W  = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  serial_readout_receiver_if.slave  bus,
  input  logic                      clear_flags,
  output logic                      frame_error,
  output logic                      overflow,
  output logic [CNT_W-1:0]          record_count
);

  localparam int TIME_PAIRS = TIME_W / 2;
  localparam int CH_PAIRS   = CH_W / 2;
  localparam int MAX_PAIRS  = (TIME_PAIRS > CH_PAIRS) ? TIME_PAIRS : CH_PAIRS;
  localparam int PAIR_W     = $clog2(MAX_PAIRS + 1);

  localparam logic [PAIR_W-1:0] TIME_LAST = PAIR_W'(TIME_PAIRS - 1);
  localparam logic [PAIR_W-1:0] CH_LAST   = PAIR_W'(CH_PAIRS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_TIME,
    S_CH
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [PAIR_W-1:0] pair_cnt;
  logic [PAIR_W-1:0] cnt_next;
  logic [TIME_W-1:0] time_sr;
  logic [CH_W-1:0]   ch_sr;
  logic [TIME_W-1:0] time_shifted;
  logic [CH_W-1:0]   ch_shifted;
  logic              time_shift_en;
  logic              ch_shift_en;
  logic              record_done;
  logic              violation;
  logic              time_ok;
  logic              ch_ok;

  assign time_ok      = bus.sending_data & bus.sl_time & ~bus.sl_ch;
  assign ch_ok        = bus.sending_data & bus.sl_ch & ~bus.sl_time;
  assign time_shifted = (time_sr << 2) | TIME_W'(bus.serial_in);
  assign ch_shifted   = (ch_sr << 2) | CH_W'(bus.serial_in);

  always_comb begin
    state_next    = state;
    cnt_next      = pair_cnt;
    time_shift_en = 1'b0;
    ch_shift_en   = 1'b0;
    record_done   = 1'b0;
    violation     = 1'b0;
    case (state)
      S_IDLE: begin
        if (time_ok) begin
          time_shift_en = 1'b1;
          if (TIME_LAST == '0) begin
            state_next = S_CH;
            cnt_next   = '0;
          end else begin
            state_next = S_TIME;
            cnt_next   = PAIR_W'(1);
          end
        end
      end
      S_TIME: begin
        if (time_ok) begin
          time_shift_en = 1'b1;
          if (pair_cnt == TIME_LAST) begin
            state_next = S_CH;
            cnt_next   = '0;
          end else begin
            cnt_next = pair_cnt + PAIR_W'(1);
          end
        end else begin
          violation  = 1'b1;
          state_next = S_IDLE;
          cnt_next   = '0;
        end
      end
      S_CH: begin
        if (ch_ok) begin
          ch_shift_en = 1'b1;
          if (pair_cnt == CH_LAST) begin
            record_done = 1'b1;
            state_next  = S_IDLE;
            cnt_next    = '0;
          end else begin
            cnt_next = pair_cnt + PAIR_W'(1);
          end
        end else begin
          // The violating cycle is deliberately not treated as a new record start.
          violation  = 1'b1;
          state_next = S_IDLE;
          cnt_next   = '0;
        end
      end
      default: begin
        state_next = S_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      pair_cnt    <= '0;
      time_sr     <= '0;
      ch_sr       <= '0;
      frame_error <= 1'b0;
    end else begin
      state       <= state_next;
      pair_cnt    <= cnt_next;
      frame_error <= violation;
      if (time_shift_en) time_sr <= time_shifted;
      if (ch_shift_en)   ch_sr   <= ch_shifted;
    end
  end

  // A finished record loads only if the slot is empty or being emptied this cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.out_valid <= 1'b0;
      bus.time_word <= '0;
      bus.ch_word   <= '0;
      overflow      <= 1'b0;
      record_count  <= '0;
    end else begin
      if (record_done && (!bus.out_valid || bus.out_ready)) begin
        bus.out_valid <= 1'b1;
        bus.time_word <= time_sr;
        bus.ch_word   <= ch_shifted;
        record_count  <= record_count + CNT_W'(1);
      end else if (bus.out_valid && bus.out_ready) begin
        bus.out_valid <= 1'b0;
      end

      if (record_done && bus.out_valid && !bus.out_ready) begin
        overflow <= 1'b1;
      end else if (clear_flags) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule
